// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage: 1-cycle latency. in_ready comes only from stage state.
// in_ready drops when the skid slot is occupied, so a stall never combinationally reaches upstream.
module pipe_stage_skid #(
  parameter int W           = 160,
  parameter int BUBBLE_ZERO = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  // Encoding equals the entry count, so occupancy is simply the state register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t       state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         accept;
  logic         consume;

  assign in_ready  = reset & (state != SKID);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  // Bubble zeroing presents a nop (ir = 0) downstream whenever the stage is empty.
  assign out_data  = ((BUBBLE_ZERO != 0) && (state == EMPTY)) ? '0 : main_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_data;
            state  <= FULL;
          end
        end
        FULL: begin
          if (accept && consume) begin
            main_q <= in_data;
          end else if (accept) begin
            skid_q <= in_data;
            state  <= SKID;
          end else if (consume) begin
            state <= EMPTY;
          end
        end
        SKID: begin
          if (consume) begin
            main_q <= skid_q;
            state  <= FULL;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic against a queue model.
module tb_pipe_stage_skid;
  localparam int W = 160;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;
  logic         in_ready,  in_ready_nb;
  logic         out_valid, out_valid_nb;
  logic [W-1:0] out_data,  out_data_nb;
  logic [1:0]   occupancy, occupancy_nb;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] last_front;

  always #5 clk = ~clk;

  pipe_stage_skid #(.W(W), .BUBBLE_ZERO(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_skid #(.W(W), .BUBBLE_ZERO(0)) dut_nb (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_nb), .in_data(in_data),
    .out_valid(out_valid_nb), .out_ready(out_ready), .out_data(out_data_nb),
    .occupancy(occupancy_nb)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] exp_dat;
    exp_dat = (q.size() > 0) ? q[0] : '0;
    chk("occ",        W'(occupancy),     W'(q.size()));
    chk("in_rdy",     W'(in_ready),      W'(q.size() < 2));
    chk("out_vld",    W'(out_valid),     W'(q.size() > 0));
    chk("out_dat",    out_data,          exp_dat);
    chk("occ_nb",     W'(occupancy_nb),  W'(q.size()));
    chk("out_dat_nb", out_data_nb,       last_front);
  endtask

  // Drive one cycle, advance the model with the pre-edge inputs, then check after the edge.
  task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    bit acc, con;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      acc = iv && (q.size() < 2);
      con = ordy && (q.size() > 0);
      if (con) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
    if (q.size() > 0) last_front = q[0];
    #1;
    check_all();
  endtask

  function automatic logic [W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    last_front = '0;
    #2;
    chk("rst_in_rdy", W'(in_ready), '0);
    chk("rst_out_vld", W'(out_valid), '0);
    chk("rst_out_dat", out_data, '0);
    chk("rst_occ", W'(occupancy), '0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all();
    chk("post_rst_in_rdy", W'(in_ready), W'(1));

    // Streaming 1..4 at full throughput
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, W'(i), 1'b1, 1'b0);
      chk("stream_dat", out_data, W'(i));
      chk("stream_occ", W'(occupancy), W'(1));
    end
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: A held, B skidded, C waits
    cycle(1'b1, W'(32'hA), 1'b0, 1'b0);
    cycle(1'b1, W'(32'hB), 1'b0, 1'b0);
    chk("bp_occ", W'(occupancy), W'(2));
    chk("bp_in_rdy", W'(in_ready), '0);
    chk("bp_dat", out_data, W'(32'hA));
    cycle(1'b1, W'(32'hC), 1'b0, 1'b0);
    chk("bp_hold_dat", out_data, W'(32'hA));
    cycle(1'b1, W'(32'hC), 1'b1, 1'b0);
    chk("bp_b_dat", out_data, W'(32'hB));
    cycle(1'b1, W'(32'hC), 1'b1, 1'b0);
    chk("bp_c_dat", out_data, W'(32'hC));
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("bp_drain_occ", W'(occupancy), '0);

    // Flush from SKID with a competing offer
    cycle(1'b1, W'(32'h11), 1'b0, 1'b0);
    cycle(1'b1, W'(32'h22), 1'b0, 1'b0);
    cycle(1'b1, W'(32'h33), 1'b1, 1'b1);
    chk("fl_occ", W'(occupancy), '0);
    chk("fl_vld", W'(out_valid), '0);
    chk("fl_dat", out_data, '0);
    chk("fl_in_rdy", W'(in_ready), W'(1));
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("fl_no33", W'(out_valid), '0);

    // Bubble behaviour with and without zeroing
    cycle(1'b1, W'(32'hDEAD), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("bub_dat_bz1", out_data, '0);
    chk("bub_dat_bz0", out_data_nb, W'(32'hDEAD));
    chk("bub_vld_bz0", W'(out_valid_nb), '0);

    // Asynchronous reset mid-cycle while in SKID
    cycle(1'b1, W'(32'h55), 1'b0, 1'b0);
    cycle(1'b1, W'(32'h66), 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_vld", W'(out_valid), '0);
    chk("arst_occ", W'(occupancy), '0);
    chk("arst_dat", out_data, '0);
    chk("arst_dat_nb", out_data_nb, '0);
    q.delete();
    last_front = '0;
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, W'(32'h77), 1'b0, 1'b0);
    chk("arst_first_dat", out_data, W'(32'h77));

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      cycle($urandom_range(0, 9) < 7, rnd_data(), $urandom_range(0, 9) < 6,
            $urandom_range(0, 31) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL take parameter W, default 160, the payload width in bits (five 32-bit stage fields: ir, aluout, rt, pc4, pc8; W >= 1).
REQ-002 The block SHALL take parameter BUBBLE_ZERO, default 1; when 1, out_data reads as all-zero whenever out_valid is 0, so an empty stage presents ir = 0 (nop).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 clears all state immediately, release is synchronised externally.
REQ-005 flush  input  1  synchronous kill of all held entries.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_ready  output  1  stage can accept one entry this cycle.
REQ-008 in_data  input  W  upstream payload.
REQ-009 out_valid  output  1  out_data holds a live entry.
REQ-010 out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 out_data  output  W  payload of the oldest held entry.
REQ-012 occupancy  output  2  number of held entries, 0..2.

Function
REQ-013 Storage SHALL be two W-bit registers: main (drives out_data) and skid (second entry).
REQ-014 State SHALL be one of EMPTY (occupancy 0), FULL (1), SKID (2); encoding is implementation choice.
REQ-015 in_ready SHALL be 1 in EMPTY and FULL and 0 in SKID, derived only from state (no combinational path from out_ready or in_valid).
REQ-016 out_valid SHALL be 1 in FULL and SKID, 0 in EMPTY.
REQ-017 Accept = in_valid & in_ready; consume = out_valid & out_ready.
REQ-018 EMPTY: accept -> main <= in_data, go FULL; else stay.
REQ-019 FULL: accept & consume -> main <= in_data, stay FULL; accept & !consume -> skid <= in_data, go SKID; !accept & consume -> go EMPTY; neither -> hold.
REQ-020 SKID: consume -> main <= skid, go FULL; else hold; in_data ignored.
REQ-021 Latency SHALL be one cycle: data accepted at edge N appears on out_data after edge N when the stage was EMPTY or consumed in the same cycle.
REQ-022 Order SHALL be preserved; no entry duplicated or dropped except by flush or reset.
REQ-023 flush = 1 SHALL force EMPTY at the next edge from any state, overriding accept and consume in that cycle; an in_valid entry offered in a flush cycle is discarded.
REQ-024 in_ready SHALL be 1 on the cycle after flush.
REQ-025 With BUBBLE_ZERO = 1, out_data SHALL equal 0 in EMPTY regardless of main contents; with BUBBLE_ZERO = 0, out_data SHALL equal main at all times.
REQ-026 Registers not loaded in a cycle SHALL hold value; stale skid contents SHALL never reach out_data.
REQ-027 occupancy SHALL equal 0/1/2 for EMPTY/FULL/SKID, registered, no glitch-dependent logic.
REQ-028 Sustained in_valid = 1 and out_ready = 1 SHALL give one entry per cycle throughput.

Reset
REQ-029 reset = 0 SHALL asynchronously force state EMPTY, main = 0, skid = 0.
REQ-030 During and after reset, before any accept: out_valid = 0, out_data = 0, occupancy = 0, in_ready = 1 after reset release (0 while reset asserted).
REQ-031 Reset asserted mid-transfer SHALL discard all held entries; the first accept after release SHALL behave as from EMPTY.

Verification
REQ-032 Reset: assert reset = 0 between edges with stage in SKID -> out_valid, occupancy, out_data become 0 before next clk edge.
REQ-033 Streaming: in_valid = 1, out_ready = 1, in_data = 1,2,3,4 on consecutive cycles -> out_data = 1,2,3,4 one cycle later, occupancy stays 1, in_ready stays 1.
REQ-034 Backpressure: load 0xA, out_ready = 0, offer 0xB -> occupancy 2, in_ready = 0, out_data = 0xA; offer 0xC held; raise out_ready -> out_data 0xB next cycle, then 0xC accepted and output in order.
REQ-035 Flush: stage in SKID holding 0x11, 0x22, flush = 1 with in_valid = 1, in_data = 0x33 -> next cycle occupancy 0, out_valid 0, out_data 0 (BUBBLE_ZERO = 1), 0x33 never appears.
REQ-036 Bubble: BUBBLE_ZERO = 1, load 0xDEAD, consume, no new input -> out_data = 0 while EMPTY; BUBBLE_ZERO = 0 same stimulus -> out_data stays 0xDEAD with out_valid = 0.
REQ-037 Random: random in_valid/out_ready/flush against a reference queue model, 10000 cycles -> no loss, duplication or reordering; occupancy matches model every cycle.
